status_display_driver: RTL and testbench
========================================

# status_display_driver

Drives the board's 4-digit multiplexed seven-segment display to show the user-control state decoded from the slide switches. Status mode shows song, ADC channel, method and buzzer flags. Raw mode shows the latest ADC sample in hex. The block sits between the switch decode / ADC sample path and the display pins, and is the output-side counterpart to the switch input mapping. It scans digits, latches samples coherently per frame, and blinks the song digit after a song change.

## Interface
- REFRESH_DIV, 100000: clk cycles per digit slot (1 ms at 100 MHz); minimum 4.
- BLANK_CYCLES, 1000: cycles at the start of each slot with all anodes off (anti-ghosting); must be < REFRESH_DIV.
- BLINK_DIV, 25000000: clk cycles per blink half-period.
- CHANGE_BLINKS, 6: half-periods the song digit blinks after a song change; even, ≥ 2.
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- raw_data_display_select  input  1  1 = raw ADC mode, 0 = status mode.
- ADC_select  input  2  selected ADC channel.
- adc_method_select  input  1  ADC method flag.
- song_select  input  3  selected song.
- buzzer_mute  input  1  buzzer muted.
- volume_control_sw  input  1  volume control enabled.
- raw_data  input  12  ADC sample.
- raw_valid  input  1  one-cycle strobe; raw_data is valid.
- seg  output  7  {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.
- an  output  4  digit anodes, active-low; an[3] is the leftmost digit.

## Operation
**Input handling**
- Control inputs are registered once; they are already debounced upstream.

**Sample latching**
- sample_hold latches raw_data on raw_valid.
- At each frame start (slot counter wraps from digit 0 back to digit 3), frame_data <= sample_hold.
- Raw-mode digits come only from frame_data, so one frame never mixes two samples.

**Scan**
- digit index cycles 3→2→1→0→3, one slot each.
- Slot counter runs 0..REFRESH_DIV-1.
- Counter values < BLANK_CYCLES: an = 4'b1111.
- Otherwise: an = one-hot-low of the digit index.

**Digit content, status mode**
- d3 = song_select (0–7).
- d2 = ADC_select (0–3).
- d1 = adc_method_select (0/1).
- d0 = {buzzer_mute, volume_control_sw} (0–3).
- dp lit on d0 only when buzzer_mute = 1.

**Digit content, raw mode**
- d3 = ADC_select.
- d2..d0 = frame_data[11:8], [7:4], [3:0].
- dp lit on d3 only.

**Hex font**
- Standard hex glyphs, e.g. 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110.
- A blanked digit drives seg = 7'h7F.

**Change blink FSM**
- IDLE: registered song_select differs from its previous registered value → go to BLINK, blink_cnt = CHANGE_BLINKS, blink timer = 0, phase = OFF.
- BLINK: the timer counts 0..BLINK_DIV-1. At wrap, phase toggles and blink_cnt decrements. When blink_cnt reaches 0, return to IDLE.
- A further song change while in BLINK restarts the sequence: blink_cnt reload, timer clear, phase OFF.
- In status mode, d3 is blanked while phase = OFF. Raw mode ignores blink, but the FSM keeps running.

## Timing
**Reset values**
- an = 4'b1111, seg = 7'h7F, dp = 1.
- Digit index = 3, slot counter = 0.
- sample_hold = frame_data = 0.
- FSM = IDLE, phase = ON.
- The previous-song register loads the current song_select, so reset causes no blink.

**Latency**
- All outputs are registered. seg/dp/an change exactly on slot boundaries and at BLANK_CYCLES within a slot.
- A control input change appears on the next unblanked slot of the affected digit. Worst case is 4·REFRESH_DIV + 2 cycles.
- A raw_valid sample is visible from the next frame start.

**Boundary conditions**
- raw_valid on the same cycle as a frame-start load: frame_data takes the old sample_hold; the new sample shows next frame.
- A mode switch mid-frame takes effect at the next slot; frame_data is unaffected.
- Reset asserted mid-slot or mid-blink returns every output and register to its reset value on the next edge.

## Test plan
Bench parameters: REFRESH_DIV=8, BLANK_CYCLES=2, BLINK_DIV=4, CHANGE_BLINKS=4.

- **Reset, then scan:** release reset → an sequence 1111(2 cycles), 0111(6), 1111(2), 1011(6), … with period 32.
- **Status mode:** song=5, ADC=2, method=1, mute=1, vol=0 → d3 seg=0010010, d2=0100100, d1=1111001, d0=0100100 with dp=0.
- **Raw mode:** raw_valid with raw_data=12'hA3F mid-frame → current frame shows the old value; next frame shows d2=A, d1=3, d0=F.
- **Song change:** song 1→2 → d3 blank for 4 cycles, lit for 4, blank for 4, lit for 4, then steady 2.
- **Change during blink:** second change mid-blink → the sequence restarts from OFF with a full 4 half-periods.
- **Reset mid-blink:** reset during BLINK → outputs return to reset values, and no blink follows the reset.

Source files
------------

// File: rtl/status_display_driver.sv
// Multiplexed 4-digit seven-segment driver: status or raw-ADC view, frame-coherent sample
// latching, and a song-digit blink after each song change.
//   state | meaning
//   IDLE  | steady display, blink phase ON
//   BLINK | song digit toggling, blink_cnt half-periods left
module status_display_driver #(
  parameter int REFRESH_DIV   = 100000,
  parameter int BLANK_CYCLES  = 1000,
  parameter int BLINK_DIV     = 25000000,
  parameter int CHANGE_BLINKS = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        raw_data_display_select,
  input  logic [1:0]  ADC_select,
  input  logic        adc_method_select,
  input  logic [2:0]  song_select,
  input  logic        buzzer_mute,
  input  logic        volume_control_sw,
  input  logic [11:0] raw_data,
  input  logic        raw_valid,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int NW = $clog2(CHANGE_BLINKS + 1);
  localparam logic [CW-1:0] SLOT_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END   = CW'(BLANK_CYCLES);
  localparam logic [BW-1:0] TMR_LAST    = BW'(BLINK_DIV - 1);
  localparam logic [NW-1:0] BLINKS_INIT = NW'(CHANGE_BLINKS);

  typedef enum logic {IDLE = 1'b0, BLINK = 1'b1} state_t;

  logic          raw_q, method_q, mute_q, vol_q;
  logic [1:0]    adc_q;
  logic [2:0]    song_q, song_prev;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0]    dig, dig_nx;
  logic [11:0]   sample_hold, frame_data, frame_nx;
  state_t        state, state_nx;
  logic          phase, phase_nx;
  logic [NW-1:0] blink_cnt, blink_cnt_nx;
  logic [BW-1:0] btimer, btimer_nx;
  logic          slot_wrap, song_chg;
  logic [3:0]    nib;
  logic          dp_on, digit_off, blank_slot;
  logic [6:0]    seg_nx;
  logic          dp_nx;
  logic [3:0]    an_nx;

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    case (v)
      4'h0: hex_glyph = 7'b1000000;
      4'h1: hex_glyph = 7'b1111001;
      4'h2: hex_glyph = 7'b0100100;
      4'h3: hex_glyph = 7'b0110000;
      4'h4: hex_glyph = 7'b0011001;
      4'h5: hex_glyph = 7'b0010010;
      4'h6: hex_glyph = 7'b0000010;
      4'h7: hex_glyph = 7'b1111000;
      4'h8: hex_glyph = 7'b0000000;
      4'h9: hex_glyph = 7'b0010000;
      4'hA: hex_glyph = 7'b0001000;
      4'hB: hex_glyph = 7'b0000011;
      4'hC: hex_glyph = 7'b1000110;
      4'hD: hex_glyph = 7'b0100001;
      4'hE: hex_glyph = 7'b0000110;
      default: hex_glyph = 7'b0001110;
    endcase
  endfunction

  assign slot_wrap = (cnt == SLOT_LAST);
  assign cnt_nx    = slot_wrap ? '0 : cnt + CW'(1);
  assign dig_nx    = slot_wrap ? dig - 2'd1 : dig;
  // Frame starts when the last digit's slot wraps back to the leftmost digit.
  assign frame_nx  = (slot_wrap && dig == 2'd0) ? sample_hold : frame_data;
  assign song_chg  = (song_q != song_prev);

  always_comb begin
    state_nx     = state;
    phase_nx     = phase;
    blink_cnt_nx = blink_cnt;
    btimer_nx    = btimer;
    if (song_chg) begin
      state_nx     = BLINK;
      phase_nx     = 1'b0;
      blink_cnt_nx = BLINKS_INIT;
      btimer_nx    = '0;
    end else if (state == BLINK) begin
      if (btimer == TMR_LAST) begin
        btimer_nx = '0;
        if (blink_cnt == NW'(1)) begin
          state_nx     = IDLE;
          phase_nx     = 1'b1;
          blink_cnt_nx = '0;
        end else begin
          phase_nx     = ~phase;
          blink_cnt_nx = blink_cnt - NW'(1);
        end
      end else begin
        btimer_nx = btimer + BW'(1);
      end
    end
  end

  // Outputs are built from next-cycle scan state so the registered pins line up with the slot.
  always_comb begin
    nib       = 4'h0;
    dp_on     = 1'b0;
    digit_off = 1'b0;
    if (raw_q) begin
      case (dig_nx)
        2'd3: begin nib = {2'b00, adc_q}; dp_on = 1'b1; end
        2'd2: nib = frame_nx[11:8];
        2'd1: nib = frame_nx[7:4];
        default: nib = frame_nx[3:0];
      endcase
    end else begin
      case (dig_nx)
        2'd3: begin nib = {1'b0, song_q}; digit_off = ~phase_nx; end
        2'd2: nib = {2'b00, adc_q};
        2'd1: nib = {3'b000, method_q};
        default: begin nib = {2'b00, mute_q, vol_q}; dp_on = mute_q; end
      endcase
    end
    blank_slot = (cnt_nx < BLANK_END);
    seg_nx     = (blank_slot || digit_off) ? 7'h7F : hex_glyph(nib);
    dp_nx      = ~(dp_on & ~blank_slot);
    an_nx      = blank_slot ? 4'hF : ~(4'b0001 << dig_nx);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      raw_q       <= raw_data_display_select;
      adc_q       <= ADC_select;
      method_q    <= adc_method_select;
      song_q      <= song_select;
      song_prev   <= song_select;
      mute_q      <= buzzer_mute;
      vol_q       <= volume_control_sw;
      cnt         <= '0;
      dig         <= 2'd3;
      sample_hold <= '0;
      frame_data  <= '0;
      state       <= IDLE;
      phase       <= 1'b1;
      blink_cnt   <= '0;
      btimer      <= '0;
      seg         <= 7'h7F;
      dp          <= 1'b1;
      an          <= 4'hF;
    end else begin
      raw_q       <= raw_data_display_select;
      adc_q       <= ADC_select;
      method_q    <= adc_method_select;
      song_q      <= song_select;
      song_prev   <= song_q;
      mute_q      <= buzzer_mute;
      vol_q       <= volume_control_sw;
      cnt         <= cnt_nx;
      dig         <= dig_nx;
      if (raw_valid) sample_hold <= raw_data;
      frame_data  <= frame_nx;
      state       <= state_nx;
      phase       <= phase_nx;
      blink_cnt   <= blink_cnt_nx;
      btimer      <= btimer_nx;
      seg         <= seg_nx;
      dp          <= dp_nx;
      an          <= an_nx;
    end
  end

endmodule

// File: tb/tb_status_display_driver.sv
// Directed bench for status_display_driver: scan timing, status/raw content, frame-coherent
// sample latching and the song-change blink sequence.
module tb_status_display_driver;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int BD = 4;
  localparam int CB = 4;
  localparam int FRAME = 4 * RD;

  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100, G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001, G5 = 7'b0010010, G7 = 7'b1111000, GA = 7'b0001000;
  localparam logic [6:0] GB = 7'b0000011, GC = 7'b1000110, GF = 7'b0001110;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        raw_sel = 1'b0;
  logic [1:0]  adc_sel = 2'd0;
  logic        method = 1'b0;
  logic [2:0]  song = 3'd1;
  logic        mute = 1'b0;
  logic        vol = 1'b0;
  logic [11:0] raw_data = 12'h000;
  logic        raw_valid = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pos = 0;
  int blink_e0 = -1000;
  bit chk_en = 1'b0;
  logic [6:0] exp_seg [4];
  logic       exp_dp  [4];

  status_display_driver #(
    .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .BLINK_DIV(BD), .CHANGE_BLINKS(CB)
  ) dut (
    .clk(clk), .reset(reset), .raw_data_display_select(raw_sel), .ADC_select(adc_sel),
    .adc_method_select(method), .song_select(song), .buzzer_mute(mute),
    .volume_control_sw(vol), .raw_data(raw_data), .raw_valid(raw_valid),
    .seg(seg), .dp(dp), .an(an)
  );

  always #5 clk = ~clk;

  // One clock; pos is the bench's own model of the position in the 32-cycle frame.
  task automatic step();
    logic r;
    int idx, k;
    logic [3:0] ea;
    logic [6:0] es;
    logic ed;
    bit skip;
    r = reset;
    @(posedge clk);
    #1;
    cyc++;
    pos = r ? 0 : (pos + 1) % FRAME;
    idx = 3 - pos / RD;
    ea = (pos % RD < BC) ? 4'b1111 : ~(4'b0001 << idx);
    checks++;
    assert (an === ea) else begin
      failures++;
      $error("FAIL an pos=%0d got=%b exp=%b", pos, an, ea);
    end
    if (chk_en) begin
      es = 7'h7F;
      ed = 1'b1;
      skip = 1'b0;
      if (pos % RD >= BC) begin
        es = exp_seg[idx];
        ed = exp_dp[idx];
        if (idx == 3 && !raw_sel) begin
          k = cyc - blink_e0;
          if (k == 0) skip = 1'b1;
          else if (k >= 1 && k < 1 + CB * BD && ((k - 1) / BD) % 2 == 0) es = 7'h7F;
        end
      end
      if (!skip) begin
        checks++;
        assert ({seg, dp} === {es, ed}) else begin
          failures++;
          $error("FAIL seg_dp pos=%0d cyc=%0d got=%b/%b exp=%b/%b", pos, cyc, seg, dp, es, ed);
        end
      end
    end
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic step_to(input int p);
    step();
    for (int i = 0; i < FRAME + 2 && pos != p; i++) step();
  endtask

  task automatic set_exp(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                         input logic [6:0] s0, input logic d3, input logic d0);
    exp_seg[3] = s3; exp_seg[2] = s2; exp_seg[1] = s1; exp_seg[0] = s0;
    exp_dp[3] = d3; exp_dp[2] = 1'b1; exp_dp[1] = 1'b1; exp_dp[0] = d0;
  endtask

  initial begin
    // Reset, then two frames of scan with the reset-time status content.
    set_exp(G1, G0, G0, G0, 1'b1, 1'b1);
    chk_en = 1'b1;
    step();
    checks++;
    assert ({an, seg, dp} === {4'hF, 7'h7F, 1'b1}) else begin
      failures++;
      $error("FAIL reset_out got=%b/%b/%b exp=1111/1111111/1", an, seg, dp);
    end
    reset = 1'b0;
    step_n(2 * FRAME);

    // Status content with mute decimal point.
    chk_en = 1'b0;
    song = 3'd5; adc_sel = 2'd2; method = 1'b1; mute = 1'b1; vol = 1'b0;
    blink_e0 = cyc + 1;
    step_n(40);
    set_exp(G5, G2, G1, G2, 1'b1, 1'b0);
    chk_en = 1'b1;
    step_n(FRAME);

    // Song change 1->2, then a second change mid-blink restarts the sequence.
    chk_en = 1'b0;
    song = 3'd1; exp_seg[3] = G1; blink_e0 = cyc + 1;
    step_n(40);
    chk_en = 1'b1;
    step_to(30);
    song = 3'd2; exp_seg[3] = G2; blink_e0 = cyc + 1;
    step_to(5);
    song = 3'd3; exp_seg[3] = G3; blink_e0 = cyc + 1;
    step_n(80);

    // Reset in the middle of a blink: reset outputs, then a steady song digit.
    step_to(26);
    song = 3'd4; exp_seg[3] = G4; blink_e0 = cyc + 1;
    step_to(7);
    reset = 1'b1;
    step();
    checks++;
    assert ({an, seg, dp} === {4'hF, 7'h7F, 1'b1}) else begin
      failures++;
      $error("FAIL reset_mid_blink got=%b/%b/%b exp=1111/1111111/1", an, seg, dp);
    end
    reset = 1'b0;
    blink_e0 = cyc - 1000;
    step_n(2 * FRAME);

    // Raw mode: sample arriving mid-frame shows from the next frame only.
    chk_en = 1'b0;
    raw_sel = 1'b1;
    step_n(40);
    set_exp(G2, G0, G0, G0, 1'b0, 1'b1);
    chk_en = 1'b1;
    step_to(12);
    raw_data = 12'hA3F; raw_valid = 1'b1;
    step();
    raw_valid = 1'b0;
    step_to(0);
    set_exp(G2, GA, G3, GF, 1'b0, 1'b1);
    step_n(FRAME);

    // Sample on the frame-start edge: frame takes the older held sample.
    step_to(12);
    raw_data = 12'h5C7; raw_valid = 1'b1;
    step();
    raw_valid = 1'b0;
    step_to(31);
    raw_data = 12'h1B2; raw_valid = 1'b1;
    step();
    raw_valid = 1'b0;
    set_exp(G2, G5, GC, G7, 1'b0, 1'b1);
    step_n(FRAME);
    set_exp(G2, G1, GB, G2, 1'b0, 1'b1);
    step_n(FRAME);

    // Mode switch mid-frame and back leaves frame_data untouched.
    step_to(12);
    chk_en = 1'b0;
    raw_sel = 1'b0;
    step_n(20);
    raw_sel = 1'b1;
    step_n(40);
    chk_en = 1'b1;
    step_n(FRAME);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
